// File: rtl/dwpe_array.sv
// dwpe_array: POYxPOX depthwise-conv PE array, one kernel tap per enabled cycle.
// Optional macro DWPE_RELU_EN clamps negative sums to zero when loading out_data.
module dwpe_array #(
   parameter int DW    = 32,
   parameter int WW    = 8,
   parameter int POY   = 3,
   parameter int POX   = 16,
   parameter int KSIZE = 3,
   localparam int NTAP = KSIZE * KSIZE,
   localparam int AW   = DW + WW + $clog2(NTAP),
   localparam int TW   = (NTAP > 1) ? $clog2(NTAP) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 dwpe_ena,
   input  logic signed [DW-1:0] dwpixel_array [POY][POX],
   input  logic                 acc_clr,
   input  logic                 wgt_wr,
   input  logic [TW-1:0]        wgt_addr,
   input  logic signed [WW-1:0] wgt_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [AW-1:0] out_data [POY][POX],
   output logic                 busy,
   output logic                 ovf_err
);

   typedef enum logic {IDLE, ACC} state_t;

   localparam int PW = DW + WW;

   state_t               state;
   logic [TW-1:0]        tap;
   logic signed [WW-1:0] wgt [NTAP];
   logic signed [AW-1:0] acc [POY][POX];
   logic signed [AW-1:0] sum [POY][POX];
   logic signed [WW-1:0] wcur;
   logic                 last;
   logic                 done;
   logic                 accept;

   function automatic logic signed [AW-1:0] relu(
      input logic signed [AW-1:0] s
   );
`ifdef DWPE_RELU_EN
      return s[AW-1] ? '0 : s;
`else
      return s;
`endif
   endfunction

   assign wcur   = wgt[tap];
   assign last   = (tap == TW'(NTAP - 1));
   assign done   = dwpe_ena && !acc_clr && last;
   assign accept = out_valid && out_ready;
   assign busy   = (state == ACC);

   // IDLE starts from an empty accumulator, so the first tap is a load
   always_comb begin
      for (int y = 0; y < POY; y++) begin
         for (int x = 0; x < POX; x++) begin
            sum[y][x] = ((state == ACC) ? acc[y][x] : '0)
                      + AW'(PW'(dwpixel_array[y][x]) * PW'(wcur));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tap       <= '0;
         out_valid <= 1'b0;
         ovf_err   <= 1'b0;
         for (int i = 0; i < NTAP; i++) begin
            wgt[i] <= '0;
         end
         for (int y = 0; y < POY; y++) begin
            for (int x = 0; x < POX; x++) begin
               acc[y][x]      <= '0;
               out_data[y][x] <= '0;
            end
         end
      end else begin
         if (wgt_wr && (int'(wgt_addr) < NTAP)) begin
            wgt[wgt_addr] <= wgt_data;
         end

         if (acc_clr) begin
            state <= IDLE;
            tap   <= '0;
            for (int y = 0; y < POY; y++) begin
               for (int x = 0; x < POX; x++) begin
                  acc[y][x] <= '0;
               end
            end
         end else if (dwpe_ena) begin
            if (last) begin
               state <= IDLE;
               tap   <= '0;
               for (int y = 0; y < POY; y++) begin
                  for (int x = 0; x < POX; x++) begin
                     acc[y][x]      <= '0;
                     out_data[y][x] <= relu(sum[y][x]);
                  end
               end
            end else begin
               state <= ACC;
               tap   <= tap + TW'(1);
               for (int y = 0; y < POY; y++) begin
                  for (int x = 0; x < POX; x++) begin
                     acc[y][x] <= sum[y][x];
                  end
               end
            end
         end

         // a completion wins over an accept; unaccepted data being replaced is an error
         if (done) begin
            out_valid <= 1'b1;
            if (out_valid && !out_ready) begin
               ovf_err <= 1'b1;
            end
         end else if (accept) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dwpe_array.sv
// tb_dwpe_array: random + directed stimulus against a behavioural
// convolution model; compares every output on each falling clock edge.
module tb_dwpe_array;

   localparam int DW    = 32;
   localparam int WW    = 8;
   localparam int POY   = 3;
   localparam int POX   = 16;
   localparam int KSIZE = 3;
   localparam int NTAP  = 9;
   localparam int AW    = 44;

   logic                 clk       = 1'b0;
   logic                 rst_n     = 1'b1;
   logic                 dwpe_ena  = 1'b0;
   logic                 acc_clr   = 1'b0;
   logic                 wgt_wr    = 1'b0;
   logic                 out_ready = 1'b0;
   logic [3:0]           wgt_addr  = '0;
   logic signed [WW-1:0] wgt_data  = '0;
   logic signed [DW-1:0] pix [POY][POX];
   logic signed [AW-1:0] od  [POY][POX];
   logic                 out_valid;
   logic                 busy;
   logic                 ovf_err;

   int vecs  = 0;
   int errs  = 0;
   bit chk_on = 1'b0;

   int     m_tap;
   int     m_w    [NTAP];
   longint m_sum  [POY][POX];
   longint m_data [POY][POX];
   bit     m_valid;
   bit     m_ovf;

   dwpe_array #(
      .DW(DW), .WW(WW), .POY(POY), .POX(POX), .KSIZE(KSIZE)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .dwpe_ena(dwpe_ena),
      .dwpixel_array(pix),
      .acc_clr(acc_clr),
      .wgt_wr(wgt_wr),
      .wgt_addr(wgt_addr),
      .wgt_data(wgt_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(od),
      .busy(busy),
      .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         if (errs <= 40)
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint mrelu(input longint s);
`ifdef DWPE_RELU_EN
      return (s < 0) ? 0 : s;
`else
      return s;
`endif
   endfunction

   task automatic model_clear();
      m_tap   = 0;
      m_valid = 0;
      m_ovf   = 0;
      for (int i = 0; i < NTAP; i++) m_w[i] = 0;
      for (int y = 0; y < POY; y++)
         for (int x = 0; x < POX; x++) begin
            m_sum[y][x]  = 0;
            m_data[y][x] = 0;
         end
   endtask

   // one clock of the convolution rules, using inputs held across the edge
   task automatic model_step();
      bit     done = 0;
      bit     acc_ok;
      longint p;
      acc_ok = m_valid && out_ready;
      if (acc_clr) begin
         m_tap = 0;
      end else if (dwpe_ena) begin
         for (int y = 0; y < POY; y++)
            for (int x = 0; x < POX; x++) begin
               p = longint'(pix[y][x]) * longint'(m_w[m_tap]);
               m_sum[y][x] = ((m_tap == 0) ? 0 : m_sum[y][x]) + p;
            end
         if (m_tap == NTAP - 1) begin
            for (int y = 0; y < POY; y++)
               for (int x = 0; x < POX; x++)
                  m_data[y][x] = mrelu(m_sum[y][x]);
            m_tap = 0;
            done  = 1;
         end else begin
            m_tap++;
         end
      end
      if (done) begin
         if (m_valid && !out_ready) m_ovf = 1;
         m_valid = 1;
      end else if (acc_ok) begin
         m_valid = 0;
      end
      if (wgt_wr && wgt_addr < NTAP) m_w[wgt_addr] = int'(wgt_data);
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("out_valid", longint'(out_valid), longint'(m_valid));
         chk("busy", longint'(busy), longint'(m_tap != 0));
         chk("ovf_err", longint'(ovf_err), longint'(m_ovf));
         for (int y = 0; y < POY; y++)
            for (int x = 0; x < POX; x++)
               chk($sformatf("out_data[%0d][%0d]", y, x), od[y][x], m_data[y][x]);
      end
   end

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
   endtask

   task automatic set_w(input int a, input int v);
      wgt_wr   = 1'b1;
      wgt_addr = a[3:0];
      wgt_data = v[7:0];
      tick();
      wgt_wr   = 1'b0;
   endtask

   task automatic fill(input int v);
      for (int y = 0; y < POY; y++)
         for (int x = 0; x < POX; x++)
            pix[y][x] = v;
   endtask

   task automatic tapn();
      dwpe_ena = 1'b1;
      tick();
      dwpe_ena = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      fill(0);
      #2;
      rst_n = 1'b0;
      model_clear();
      chk_on = 1'b1;
      #1;
      chk("reset out_valid", longint'(out_valid), 0);
      chk("reset busy", longint'(busy), 0);
      chk("reset out_data", od[2][15], 0);
      tick();
      tick();
      rst_n = 1'b1;

      // all weights 1, all pixels 2 -> 18
      for (int i = 0; i < NTAP; i++) set_w(i, 1);
      fill(2);
      for (int t = 0; t < NTAP; t++) begin
         tapn();
         if (t == 7) chk("ones early valid", longint'(out_valid), 0);
      end
      chk("ones valid", longint'(out_valid), 1);
      chk("ones [0][0]", od[0][0], 18);
      chk("ones [2][15]", od[2][15], 18);
      chk("ones [1][7]", od[1][7], 18);
      drain();
      chk("ones accepted", longint'(out_valid), 0);

      // single centre weight of -3
      for (int i = 0; i < NTAP; i++) set_w(i, (i == 4) ? -3 : 0);
      for (int t = 0; t < NTAP; t++) begin
         for (int y = 0; y < POY; y++)
            for (int x = 0; x < POX; x++)
               pix[y][x] = int'($urandom_range(40)) - 20;
         if (t == 4) pix[1][5] = 7;
         tapn();
      end
`ifdef DWPE_RELU_EN
      chk("neg tap [1][5]", od[1][5], 0);
`else
      chk("neg tap [1][5]", od[1][5], -21);
`endif
      drain();

      // two idle cycles between taps
      for (int i = 0; i < NTAP; i++) set_w(i, 1);
      fill(2);
      for (int t = 0; t < NTAP; t++) begin
         tapn();
         if (t < NTAP - 1) begin
            repeat (2) begin
               tick();
               chk("gap busy", longint'(busy), 1);
            end
         end
      end
      chk("gap valid", longint'(out_valid), 1);
      chk("gap [2][3]", od[2][3], 18);
      drain();

      // abort after five taps, then a clean pass of ones
      fill(5);
      repeat (5) tapn();
      acc_clr = 1'b1;
      tick();
      acc_clr = 1'b0;
      chk("clr busy", longint'(busy), 0);
      fill(1);
      repeat (NTAP) tapn();
      chk("clr [0][9]", od[0][9], 9);
      drain();

      // two passes with no accept
      fill(2);
      repeat (NTAP) tapn();
      chk("ovf first", longint'(ovf_err), 0);
      fill(3);
      repeat (NTAP) tapn();
      chk("ovf set", longint'(ovf_err), 1);
      chk("ovf data", od[1][1], 27);
      chk("ovf valid", longint'(out_valid), 1);
      drain();

      // reset mid-pass
      fill(2);
      repeat (4) tapn();
      rst_n = 1'b0;
      model_clear();
      #1;
      chk("rst ovf", longint'(ovf_err), 0);
      chk("rst busy", longint'(busy), 0);
      chk("rst data", od[1][1], 0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < NTAP; i++) set_w(i, 1);
      fill(2);
      repeat (NTAP) tapn();
      chk("post rst data", od[0][4], 18);
      drain();

      for (int c = 0; c < 2500; c++) begin
         dwpe_ena  = ($urandom % 4) != 0;
         acc_clr   = ($urandom % 50) == 0;
         out_ready = ($urandom % 3) != 0;
         wgt_wr    = ($urandom % 6) == 0;
         wgt_addr  = 4'($urandom % 16);
         wgt_data  = 8'($urandom);
         for (int y = 0; y < POY; y++)
            for (int x = 0; x < POX; x++)
               pix[y][x] = (($urandom % 4) == 0) ? 32'($urandom)
                                                 : 32'(int'($urandom % 64) - 32);
         if (c == 1200) begin
            rst_n = 1'b0;
            model_clear();
         end
         if (c == 1202) rst_n = 1'b1;
         tick();
      end

      dwpe_ena  = 1'b0;
      acc_clr   = 1'b0;
      wgt_wr    = 1'b0;
      out_ready = 1'b0;
      tick();
      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
